// File: rtl/slv_guard_rst_pkg.sv
// Shared types for the per-subordinate reset sequencer.
// Timeout/FAULT support is compiled in only with SLV_GUARD_RST_TIMEOUT_EN.
package slv_guard_rst_pkg;

  localparam int DefaultCntWidth = 8;

  typedef logic [DefaultCntWidth-1:0] rst_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FAULT   = 3'd5
  } rst_state_e;

  function automatic logic sub_rst_active(input rst_state_e s);
    return (s == ST_ASSERT) || (s == ST_HOLD) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/slv_guard_rst_fsm.sv
// Single-subordinate reset sequencer: isolate, reset, wait ack, hold, release.
// SLV_GUARD_RST_TIMEOUT_EN enables the ack timeout and the sticky FAULT state.
//
//   state   | meaning
//   IDLE    | waiting for a reset request
//   ISOLATE | subordinate fenced off, reset not yet driven
//   ASSERT  | reset driven, waiting for rst_stat_i to go high
//   HOLD    | reset held for the programmed time after ack
//   RELEASE | reset dropped, waiting for rst_stat_i to go low
//   FAULT   | ack timed out; fenced and in reset until cleared
module slv_guard_rst_fsm
  import slv_guard_rst_pkg::*;
#(
  parameter int CntWidth = DefaultCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rst_req_i,
  input  logic                rst_stat_i,
  input  logic [CntWidth-1:0] iso_cycles_i,
  input  logic [CntWidth-1:0] hold_cycles_i,
  input  logic [CntWidth-1:0] timeout_i,
  input  logic                clr_i,
  output logic                isolate_o,
  output logic                sub_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                fault_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  rst_state_e          r_state;
  rst_state_e          w_next;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_inc;
  logic [CntWidth-1:0] w_iso_eff;
  logic [CntWidth-1:0] w_hold_eff;
  logic                r_done;
  logic                w_tmo;

  assign w_cnt_inc  = (r_cnt == CntMax) ? r_cnt : r_cnt + CntWidth'(1);
  assign w_iso_eff  = (iso_cycles_i == '0) ? CntWidth'(1) : iso_cycles_i;
  assign w_hold_eff = (hold_cycles_i == '0) ? CntWidth'(1) : hold_cycles_i;

`ifdef SLV_GUARD_RST_TIMEOUT_EN
  // >= rather than == so a live decrease of timeout_i cannot strand the wait
  assign w_tmo = (r_cnt >= timeout_i);
`else
  logic w_unused;
  assign w_tmo    = 1'b0;
  assign w_unused = ^{timeout_i, clr_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((w_next != r_state) || (r_state == ST_IDLE)) ? '0 : w_cnt_inc;
      r_done  <= (r_state == ST_RELEASE) && (w_next == ST_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (rst_req_i) w_next = ST_ISOLATE;
      ST_ISOLATE: if (w_cnt_inc >= w_iso_eff) w_next = ST_ASSERT;
      ST_ASSERT: begin
        if (rst_stat_i)  w_next = ST_HOLD;
        else if (w_tmo)  w_next = ST_FAULT;
      end
      ST_HOLD:    if (w_cnt_inc >= w_hold_eff) w_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!rst_stat_i) w_next = ST_IDLE;
        else if (w_tmo)  w_next = ST_FAULT;
      end
      ST_FAULT: begin
`ifdef SLV_GUARD_RST_TIMEOUT_EN
        if (clr_i) w_next = ST_IDLE;
`else
        w_next = ST_IDLE;
`endif
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    isolate_o = (r_state != ST_IDLE);
    sub_rst_o = sub_rst_active(r_state);
    busy_o    = (r_state != ST_IDLE);
    done_o    = r_done;
    fault_o   = 1'b0;
`ifdef SLV_GUARD_RST_TIMEOUT_EN
    fault_o   = (r_state == ST_FAULT);
`endif
  end

endmodule

// File: rtl/slv_guard_rst_ctrl.sv
// Per-subordinate reset sequencer array; one independent FSM per subordinate.
// Timeout/FAULT behaviour depends on SLV_GUARD_RST_TIMEOUT_EN.
module slv_guard_rst_ctrl
  import slv_guard_rst_pkg::*;
#(
  parameter int NumSub   = 1,
  parameter int CntWidth = DefaultCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumSub-1:0]   rst_req_i,
  input  logic [NumSub-1:0]   rst_stat_i,
  input  logic [CntWidth-1:0] iso_cycles_i,
  input  logic [CntWidth-1:0] hold_cycles_i,
  input  logic [CntWidth-1:0] timeout_i,
  input  logic [NumSub-1:0]   clr_i,
  output logic [NumSub-1:0]   isolate_o,
  output logic [NumSub-1:0]   sub_rst_o,
  output logic [NumSub-1:0]   busy_o,
  output logic [NumSub-1:0]   done_o,
  output logic [NumSub-1:0]   fault_o,
  output logic                irq_o
);

  for (genvar g = 0; g < NumSub; g++) begin : g_sub
    slv_guard_rst_fsm #(
      .CntWidth (CntWidth)
    ) u_fsm (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rst_req_i     (rst_req_i[g]),
      .rst_stat_i    (rst_stat_i[g]),
      .iso_cycles_i  (iso_cycles_i),
      .hold_cycles_i (hold_cycles_i),
      .timeout_i     (timeout_i),
      .clr_i         (clr_i[g]),
      .isolate_o     (isolate_o[g]),
      .sub_rst_o     (sub_rst_o[g]),
      .busy_o        (busy_o[g]),
      .done_o        (done_o[g]),
      .fault_o       (fault_o[g])
    );
  end

  assign irq_o = |fault_o;

endmodule
